// File: rtl/eth_mac_pkg.sv
// Shared MAC types: TX arbiter state encoding and the FIFO beat layout.
package eth_mac_pkg;

   // Beat data width of the MAC TX/RX FIFO datapath
   localparam int MAC_DATA_W = 8;

   // Write-side controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } txarb_state_t;

   // One FIFO entry: end-of-frame flag above the beat data
   typedef struct packed {
      logic                  last;
      logic [MAC_DATA_W-1:0] data;
   } fifo_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester
// found after ptr, wrapping modulo NREQ. Shared by the TX and RX paths.
module rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt
);

   logic found;
   int   idx;

   // Search ptr+1, ptr+2, ... and stop at the first asserted request
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = (int'(ptr) + i) % NREQ;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_fifo_arbiter.sv
// MAC TX FIFO write-side controller. Round-robin shares the FIFO write port
// among NREQ frame sources, locking the grant for a whole frame, gating on
// FIFO full and truncating frames longer than MAX_LEN beats.
module tx_fifo_arbiter
   import eth_mac_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int DATA_W  = 8,
   parameter int MAX_LEN = 1518
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ-1:0][DATA_W-1:0]  req_data,
   input  logic [NREQ-1:0]              req_last,
   output logic [NREQ-1:0]              req_ready,
   output logic                         fifo_we,
   output logic [DATA_W:0]              fifo_wdata,
   input  logic                         fifo_wfull,
   output logic [NREQ-1:0]              grant,
   output logic                         busy,
   output logic                         trunc
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);

   txarb_state_t      state;
   logic [PTR_W-1:0]  rr_ptr;
   logic [LEN_W-1:0]  len;

   logic [NREQ-1:0]   arb_gnt;
   logic [PTR_W-1:0]  g_idx;
   logic [DATA_W-1:0] g_data;
   logic              g_valid;
   logic              g_last;
   logic              at_limit;
   logic              xfer_fire;
   logic              drain_fire;

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr_arbiter (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (arb_gnt)
   );

   // Select the granted source's beat and encode the owner index
   always_comb begin
      g_idx  = '0;
      g_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            g_idx  = PTR_W'(i);
            g_data = req_data[i];
         end
      end
   end

   assign g_valid    = |(req_valid & grant);
   assign g_last     = |(req_last & grant);
   assign at_limit   = (len == LEN_LAST);
   assign xfer_fire  = (state == XFER) && g_valid && !fifo_wfull;
   assign drain_fire = (state == DRAIN) && g_valid;

   // Handshake and FIFO write port; only the owner ever sees ready
   always_comb begin
      req_ready  = '0;
      fifo_we    = 1'b0;
      fifo_wdata = '0;
      case (state)
         XFER: begin
            req_ready  = grant & {NREQ{~fifo_wfull}};
            fifo_we    = g_valid & ~fifo_wfull;
            fifo_wdata = {g_last | at_limit, g_data};
         end
         DRAIN: begin
            req_ready = grant;
         end
         default: begin
            req_ready  = '0;
         end
      endcase
   end

   assign busy = (state != IDLE);

   // Arbitration FSM with frame-length counter and round-robin pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         grant  <= '0;
         len    <= '0;
         rr_ptr <= PTR_W'(NREQ - 1);
         trunc  <= 1'b0;
      end else begin
         trunc <= 1'b0;
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant <= arb_gnt;
                  len   <= '0;
                  state <= XFER;
               end
            end
            XFER: begin
               if (xfer_fire) begin
                  len <= len + LEN_W'(1);
                  if (g_last) begin
                     // A last on the limit beat is still a normal end
                     rr_ptr <= g_idx;
                     grant  <= '0;
                     state  <= IDLE;
                  end else if (at_limit) begin
                     trunc <= 1'b1;
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (drain_fire && g_last) begin
                  rr_ptr <= g_idx;
                  grant  <= '0;
                  state  <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule
